// File: rtl/if_id_fetch.sv
// -----------------------------------------------------------------------------
// if_id_fetch
//
// Instruction-fetch stage of a five-stage MIPS pipeline. It owns the program
// counter, presents the fetch request to a combinational-read instruction
// memory, and holds the IF/ID pipeline register consumed by decode.
//
// Optional feature macro: IF_ID_PERF_EN
//   defined   -> saturating 16-bit stall and flush counters are built
//   undefined -> stall_count / flush_count are tied to zero
//
// Ports
//   clk, reset_n        clock (rising edge) and asynchronous active-low reset
//   hazard_detected     load-use stall: hold PC and IF/ID
//   branch_taken        decode resolved a taken branch/jump this cycle
//   branch_target       redirect address (bits [1:0] ignored)
//   imem_req/imem_addr  fetch request and address (addr is the PC register)
//   imem_ready/rdata    instruction word valid this cycle for imem_addr
//   instr_IF_ID         IF/ID instruction word
//   pc_plus4_IF_ID      IF/ID PC+4 of that instruction
//   valid_IF_ID         IF/ID holds a real instruction (0 = bubble)
//   RegisterRs/Rt_IF_ID rs/rt fields of instr_IF_ID for the hazard detector
//   stall_count         saturating count of stall cycles
//   flush_count         saturating count of branch flushes
// -----------------------------------------------------------------------------
module if_id_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        hazard_detected,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_IF_ID,
   output logic [31:0] pc_plus4_IF_ID,
   output logic        valid_IF_ID,
   output logic [4:0]  RegisterRs_IF_ID,
   output logic [4:0]  RegisterRt_IF_ID,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic        imem_req_q, imem_req_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        valid_q, valid_d;

   // One-hot view of the action taken this edge; only meaningful in RUN.
   logic        do_flush;
   logic        do_stall;
   logic [31:0] pc_inc;

   assign pc_inc = pc_q + 32'd4;  // wraps modulo 2^32 by width

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned in this block gets a default here, so no
      // path leaves it unassigned and no latch is inferred.
      state_d    = state_q;
      imem_req_d = imem_req_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      do_flush   = 1'b0;
      do_stall   = 1'b0;

      unique case (state_q)
         BOOT: begin
            // All inputs ignored; PC held, IF/ID loaded with a bubble.
            state_d    = RUN;
            imem_req_d = 1'b1;
            instr_d    = NOP_INSTR;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
         end

         RUN: begin
            imem_req_d = 1'b1;
            if (branch_taken) begin
               // Redirect wins over stall and memory wait.
               do_flush   = 1'b1;
               pc_d       = {branch_target[31:2], 2'b00};
               instr_d    = NOP_INSTR;
               pc_plus4_d = 32'd0;
               valid_d    = 1'b0;
            end else if (hazard_detected) begin
               // Everything holds via the defaults; imem_rdata is discarded.
               do_stall = 1'b1;
            end else if (!imem_ready) begin
               instr_d    = NOP_INSTR;
               pc_plus4_d = 32'd0;
               valid_d    = 1'b0;
            end else begin
               pc_d       = pc_inc;
               instr_d    = imem_rdata;
               pc_plus4_d = pc_inc;
               valid_d    = 1'b1;
            end
         end

         default: state_d = BOOT;
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= BOOT;
         imem_req_q <= 1'b0;
         pc_q       <= RESET_PC;
         instr_q    <= NOP_INSTR;
         pc_plus4_q <= 32'd0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         imem_req_q <= imem_req_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   // --------------------------------------------------------------------------
   // Optional performance counters
   // --------------------------------------------------------------------------
`ifdef IF_ID_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (do_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (do_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`else
   logic unused_perf;
   assign unused_perf = do_stall ^ do_flush;
   assign stall_count = 16'd0;
   assign flush_count = 16'd0;
`endif

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign imem_req         = imem_req_q;
   assign imem_addr        = pc_q;
   assign instr_IF_ID      = instr_q;
   assign pc_plus4_IF_ID   = pc_plus4_q;
   assign valid_IF_ID      = valid_q;
   assign RegisterRs_IF_ID = instr_q[25:21];
   assign RegisterRt_IF_ID = instr_q[20:16];

endmodule

// File: tb/tb_if_id_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_id_fetch
//
// Directed bench for if_id_fetch. Expected post-edge observations are pushed
// onto a scoreboard queue as each step is driven, then popped and compared
// one time unit after the rising edge. Instruction memory is a combinational
// function of the address.
// -----------------------------------------------------------------------------
module tb_if_id_fetch;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0020;
`ifdef IF_ID_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      logic        req;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [15:0] stalls;
      logic [15:0] flushes;
   } obs_t;

   logic        clk;
   logic        reset_n;
   logic        hazard_detected;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr_IF_ID;
   logic [31:0] pc_plus4_IF_ID;
   logic        valid_IF_ID;
   logic [4:0]  RegisterRs_IF_ID;
   logic [4:0]  RegisterRt_IF_ID;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   int   vectors = 0;
   int   miscompares = 0;
   obs_t sb_q[$];

   if_id_fetch #(
      .RESET_PC (RESET_PC),
      .NOP_INSTR(NOP_INSTR)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .hazard_detected (hazard_detected),
      .branch_taken    (branch_taken),
      .branch_target   (branch_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .instr_IF_ID     (instr_IF_ID),
      .pc_plus4_IF_ID  (pc_plus4_IF_ID),
      .valid_IF_ID     (valid_IF_ID),
      .RegisterRs_IF_ID(RegisterRs_IF_ID),
      .RegisterRt_IF_ID(RegisterRt_IF_ID),
      .stall_count     (stall_count),
      .flush_count     (flush_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog: the sequence is a few dozen cycles.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // PC-indexed instruction memory; 0x10 holds a lw with rs=1, rt=2.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h8C22_0000;
      return 32'h2400_0000 + a;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] addr, input logic req, input logic [31:0] instr,
                       input logic [31:0] pc4, input logic valid,
                       input int stalls, input int flushes);
      obs_t e;
      e.addr    = addr;
      e.req     = req;
      e.instr   = instr;
      e.pc4     = pc4;
      e.valid   = valid;
      e.stalls  = PERF ? 16'(stalls)  : 16'd0;
      e.flushes = PERF ? 16'(flushes) : 16'd0;
      sb_q.push_back(e);
   endtask

   // Expect a real instruction fetched from address a, with PC now at next.
   task automatic push_fetch(input logic [31:0] a, input int stalls, input int flushes);
      push(a + 32'd4, 1'b1, mem_word(a), a + 32'd4, 1'b1, stalls, flushes);
   endtask

   task automatic push_bubble(input logic [31:0] pc, input int stalls, input int flushes);
      push(pc, 1'b1, NOP_INSTR, 32'd0, 1'b0, stalls, flushes);
   endtask

   task automatic check_now(input string tag);
      obs_t e;
      vectors++;
      assert (sb_q.size() != 0)
      else begin
         miscompares++;
         $error("FAIL %s: scoreboard empty, observed addr %h expected an entry", tag, imem_addr);
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         cmp({tag, ".addr"},  imem_addr,            e.addr);
         cmp({tag, ".req"},   32'(imem_req),        32'(e.req));
         cmp({tag, ".instr"}, instr_IF_ID,          e.instr);
         cmp({tag, ".pc4"},   pc_plus4_IF_ID,       e.pc4);
         cmp({tag, ".valid"}, 32'(valid_IF_ID),     32'(e.valid));
         cmp({tag, ".rs"},    32'(RegisterRs_IF_ID), 32'(e.instr[25:21]));
         cmp({tag, ".rt"},    32'(RegisterRt_IF_ID), 32'(e.instr[20:16]));
         cmp({tag, ".stall"}, 32'(stall_count),     32'(e.stalls));
         cmp({tag, ".flush"}, 32'(flush_count),     32'(e.flushes));
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      check_now(tag);
   endtask

   initial begin
      reset_n         = 1'b0;
      hazard_detected = 1'b0;
      branch_taken    = 1'b0;
      branch_target   = 32'd0;
      imem_ready      = 1'b1;

      // Reset state, checked while reset is still asserted.
      #12;
      push(RESET_PC, 1'b0, NOP_INSTR, 32'd0, 1'b0, 0, 0);
      check_now("reset");
      reset_n = 1'b1;

      // BOOT edge: request comes up, IF/ID is a bubble, PC unchanged.
      push_bubble(32'h0, 0, 0);            step("boot");
      push_fetch(32'h00, 0, 0);            step("fetch00");
      push_fetch(32'h04, 0, 0);            step("fetch04");
      push_fetch(32'h08, 0, 0);            step("fetch08");
      push_fetch(32'h0C, 0, 0);            step("fetch0c");
      push_fetch(32'h10, 0, 0);            step("fetch10_lw");

      // Two-cycle load-use stall: IF/ID and PC hold.
      hazard_detected = 1'b1;
      push_fetch(32'h10, 1, 0);            step("stall1");
      push_fetch(32'h10, 2, 0);            step("stall2");
      hazard_detected = 1'b0;
      push_fetch(32'h14, 2, 0);            step("after_stall");

      // Redirect to 0x100; low address bits are forced to zero.
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0103;
      push_bubble(32'h100, 2, 1);          step("flush");
      branch_taken  = 1'b0;
      push_fetch(32'h100, 2, 1);           step("target");

      // Redirect and stall together: redirect wins, stall not counted.
      branch_taken    = 1'b1;
      hazard_detected = 1'b1;
      branch_target   = 32'h0000_0200;
      push_bubble(32'h200, 2, 2);          step("flush_over_stall");
      branch_taken    = 1'b0;
      hazard_detected = 1'b0;
      push_fetch(32'h200, 2, 2);           step("fetch200");

      // Three cycles of memory wait: bubbles enter, PC holds.
      imem_ready = 1'b0;
      push_bubble(32'h204, 2, 2);          step("wait1");
      push_bubble(32'h204, 2, 2);          step("wait2");
      push_bubble(32'h204, 2, 2);          step("wait3");
      imem_ready = 1'b1;
      push_fetch(32'h204, 2, 2);           step("resume");

      // PC wrap from 0xFFFF_FFFC.
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      push_bubble(32'hFFFF_FFFC, 2, 3);    step("flush_top");
      branch_taken  = 1'b0;
      push(32'h0, 1'b1, mem_word(32'hFFFF_FFFC), 32'h0, 1'b1, 2, 3);
      step("wrap");

      // Stall in progress, then asynchronous reset between edges.
      hazard_detected = 1'b1;
      push(32'h0, 1'b1, mem_word(32'hFFFF_FFFC), 32'h0, 1'b1, 3, 3);
      step("stall_pre_reset");
      #2;
      reset_n = 1'b0;
      #1;
      push(RESET_PC, 1'b0, NOP_INSTR, 32'd0, 1'b0, 0, 0);
      check_now("async_reset");

      // Restart from BOOT; inputs ignored during the BOOT edge.
      #3;
      reset_n       = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0300;
      push_bubble(32'h0, 0, 0);            step("reboot_ignores_inputs");
      branch_taken    = 1'b0;
      hazard_detected = 1'b0;
      push_fetch(32'h00, 0, 0);            step("refetch00");
      push_fetch(32'h04, 0, 0);            step("refetch04");

      vectors++;
      assert (sb_q.size() == 0)
      else begin
         miscompares++;
         $error("FAIL sb_drain: observed %0d entries left expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
